// File: rtl/arb_types.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_side_t  : requester identity, used for the round-robin last-grant record
package arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_side_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch
// side (I) and the load/store side (D). Registered grant, round-robin
// tie-break, full latching of the granted transaction.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no transaction in flight, pmem_* driven 0, pick a requester
// SERVE_I | latched I-side read presented downstream until pmem_resp
// SERVE_D | latched D-side read/write presented downstream until pmem_resp
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read, i_addr           I-side read request (held until i_resp)
//   i_rdata, i_resp          I-side read data / completion pulse
//   d_read, d_write, d_addr, d_wdata, d_byte_enable
//                            D-side request (held until d_resp)
//   d_rdata, d_resp          D-side read data / completion pulse
//   pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable
//                            downstream request, driven from latched registers
//   pmem_rdata, pmem_resp    downstream read data / completion
module mem_port_arbiter
    import arb_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_read,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_resp,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_WIDTH-1:0]   pmem_addr,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_t state_q, state_d;
    arb_side_t  last_grant_q;
    arb_side_t  grant_side;
    logic       grant_valid;

    logic                  txn_read_q;
    logic                  txn_write_q;
    logic [ADDR_WIDTH-1:0] txn_addr_q;
    logic [DATA_WIDTH-1:0] txn_wdata_q;
    logic [BE_WIDTH-1:0]   txn_be_q;

    logic i_req;
    logic d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Pick and next state. On contention the side that did not win last time gets it.
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_side  = last_grant_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_valid = 1'b1;
                    grant_side  = (last_grant_q == ARB_I) ? ARB_D : ARB_I;
                end else if (i_req) begin
                    grant_valid = 1'b1;
                    grant_side  = ARB_I;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_side  = ARB_D;
                end
                if (grant_valid) begin
                    state_d = (grant_side == ARB_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction latch. A D-side request with both read and write set is
    // taken as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ARB_I;
            txn_read_q   <= 1'b0;
            txn_write_q  <= 1'b0;
            txn_addr_q   <= '0;
            txn_wdata_q  <= '0;
            txn_be_q     <= '0;
        end else if (grant_valid) begin
            last_grant_q <= grant_side;
            if (grant_side == ARB_I) begin
                txn_read_q  <= 1'b1;
                txn_write_q <= 1'b0;
                txn_addr_q  <= i_addr;
                txn_wdata_q <= '0;
                txn_be_q    <= '1;
            end else begin
                txn_read_q  <= ~d_write;
                txn_write_q <= d_write;
                txn_addr_q  <= d_addr;
                txn_wdata_q <= d_wdata;
                txn_be_q    <= d_write ? d_byte_enable : {BE_WIDTH{1'b1}};
            end
        end
    end

    // Downstream drive and completion. Reset held in a serve cycle
    // suppresses the response so an aborted transaction never completes.
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_addr        = '0;
        pmem_wdata       = '0;
        pmem_byte_enable = '0;
        i_resp           = 1'b0;
        d_resp           = 1'b0;
        if (state_q == SERVE_I || state_q == SERVE_D) begin
            pmem_read        = txn_read_q;
            pmem_write       = txn_write_q;
            pmem_addr        = txn_addr_q;
            pmem_wdata       = txn_wdata_q;
            pmem_byte_enable = txn_be_q;
        end
        if (state_q == SERVE_I) begin
            i_resp = pmem_resp & ~rst;
        end
        if (state_q == SERVE_D) begin
            d_resp = pmem_resp & ~rst;
        end
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 2 time units after
// the rising edge; outputs are checked 1 unit later, well clear of the edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_read           (i_read),
        .i_addr           (i_addr),
        .i_rdata          (i_rdata),
        .i_resp           (i_resp),
        .d_read           (d_read),
        .d_write          (d_write),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_byte_enable    (d_byte_enable),
        .d_rdata          (d_rdata),
        .d_resp           (d_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_addr        (pmem_addr),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byte_enable = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // reset state
        step(); step();
        #1;
        chk("rst_pmem_read",  {31'd0, pmem_read}, 32'd0);
        chk("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
        chk("rst_pmem_addr",  pmem_addr, 32'd0);
        chk("rst_pmem_wdata", pmem_wdata, 32'd0);
        chk("rst_pmem_be",    {28'd0, pmem_byte_enable}, 32'd0);
        chk("rst_i_resp",     {31'd0, i_resp}, 32'd0);
        chk("rst_d_resp",     {31'd0, d_resp}, 32'd0);
        rst = 1'b0;

        // I-only read of 0x60, 2-cycle memory latency
        step();
        i_read = 1'b1; i_addr = 32'h60;
        #1;
        chk("i1_idle_read", {31'd0, pmem_read}, 32'd0);
        step();
        #1;
        chk("i1_pmem_read", {31'd0, pmem_read}, 32'd1);
        chk("i1_pmem_addr", pmem_addr, 32'h60);
        chk("i1_pmem_be",   {28'd0, pmem_byte_enable}, 32'hF);
        chk("i1_wait_resp", {31'd0, i_resp}, 32'd0);
        step();
        pmem_resp = 1'b1; pmem_rdata = 32'h00A00093;
        #1;
        chk("i1_i_resp",  {31'd0, i_resp}, 32'd1);
        chk("i1_i_rdata", i_rdata, 32'h00A00093);
        chk("i1_d_resp",  {31'd0, d_resp}, 32'd0);
        step();
        pmem_resp = 1'b0; i_read = 1'b0;
        #1;
        chk("i1_after_read", {31'd0, pmem_read}, 32'd0);
        chk("i1_after_resp", {31'd0, i_resp}, 32'd0);

        // D-only write of 0xDEADBEEF to 0x100, byte enables 0011
        step();
        d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
        step();
        #1;
        chk("d1_pmem_write", {31'd0, pmem_write}, 32'd1);
        chk("d1_pmem_read",  {31'd0, pmem_read}, 32'd0);
        chk("d1_pmem_addr",  pmem_addr, 32'h100);
        chk("d1_pmem_wdata", pmem_wdata, 32'hDEADBEEF);
        chk("d1_pmem_be",    {28'd0, pmem_byte_enable}, 32'h3);
        step();
        pmem_resp = 1'b1; pmem_rdata = 32'h0;
        #1;
        chk("d1_d_resp", {31'd0, d_resp}, 32'd1);
        chk("d1_i_resp", {31'd0, i_resp}, 32'd0);
        step();
        pmem_resp = 1'b0; d_write = 1'b0; d_byte_enable = 4'b0000;

        // simultaneous I read 0x4 and D read 0x200 right after reset: D first
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_read = 1'b1; i_addr = 32'h4;
        d_read = 1'b1; d_addr = 32'h200;
        step();
        #1;
        chk("sim_first_addr", pmem_addr, 32'h200);
        chk("sim_first_read", {31'd0, pmem_read}, 32'd1);
        chk("sim_first_be",   {28'd0, pmem_byte_enable}, 32'hF);
        step();
        pmem_resp = 1'b1; pmem_rdata = 32'h11111111;
        #1;
        chk("sim_d_resp",  {31'd0, d_resp}, 32'd1);
        chk("sim_d_rdata", d_rdata, 32'h11111111);
        chk("sim_d_iresp", {31'd0, i_resp}, 32'd0);
        step();
        pmem_resp = 1'b0; d_read = 1'b0;
        #1;
        chk("sim_gap_read", {31'd0, pmem_read}, 32'd0);
        step();
        #1;
        chk("sim_second_addr", pmem_addr, 32'h4);
        chk("sim_second_read", {31'd0, pmem_read}, 32'd1);
        pmem_resp = 1'b1; pmem_rdata = 32'h22222222;
        #1;
        chk("sim_i_resp",  {31'd0, i_resp}, 32'd1);
        chk("sim_i_rdata", i_rdata, 32'h22222222);
        chk("sim_i_dresp", {31'd0, d_resp}, 32'd0);
        step();
        pmem_resp = 1'b0; i_read = 1'b0;
        step();

        // continuous contention: D, I, D, I, D, I
        i_read = 1'b1; i_addr = 32'h1000;
        d_read = 1'b1; d_addr = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            step();
            pmem_resp = 1'b1; pmem_rdata = 32'hC0DE0000 + k;
            #1;
            if (k % 2 == 0) begin
                chk($sformatf("rr%0d_addr", k),   pmem_addr, 32'h2000);
                chk($sformatf("rr%0d_dresp", k),  {31'd0, d_resp}, 32'd1);
                chk($sformatf("rr%0d_iresp", k),  {31'd0, i_resp}, 32'd0);
                chk($sformatf("rr%0d_drdata", k), d_rdata, 32'hC0DE0000 + k);
            end else begin
                chk($sformatf("rr%0d_addr", k),   pmem_addr, 32'h1000);
                chk($sformatf("rr%0d_iresp", k),  {31'd0, i_resp}, 32'd1);
                chk($sformatf("rr%0d_dresp", k),  {31'd0, d_resp}, 32'd0);
                chk($sformatf("rr%0d_irdata", k), i_rdata, 32'hC0DE0000 + k);
            end
            step();
            pmem_resp = 1'b0;
            #1;
            chk($sformatf("rr%0d_gap", k), {31'd0, pmem_read}, 32'd0);
        end
        i_read = 1'b0; d_read = 1'b0;
        step();

        // D address changes mid-transaction; latched 0x200 must hold
        d_read = 1'b1; d_addr = 32'h200;
        step();
        #1;
        chk("hold_addr0", pmem_addr, 32'h200);
        d_addr = 32'h300;
        #1;
        chk("hold_addr1", pmem_addr, 32'h200);
        step();
        #1;
        chk("hold_addr2", pmem_addr, 32'h200);
        pmem_resp = 1'b1; pmem_rdata = 32'h33333333;
        #1;
        chk("hold_addr3", pmem_addr, 32'h200);
        chk("hold_dresp", {31'd0, d_resp}, 32'd1);
        step();
        pmem_resp = 1'b0; d_read = 1'b0;
        step();

        // reset during SERVE_I, late pmem_resp afterwards is ignored
        i_read = 1'b1; i_addr = 32'h40;
        step();
        #1;
        chk("rmid_serve_read", {31'd0, pmem_read}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid_no_resp0", {31'd0, i_resp}, 32'd0);
        step();
        rst = 1'b0; i_read = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = 32'h44444444;
        #1;
        chk("rmid_idle_read", {31'd0, pmem_read}, 32'd0);
        chk("rmid_no_resp1",  {31'd0, i_resp}, 32'd0);
        chk("rmid_no_dresp",  {31'd0, d_resp}, 32'd0);
        step();
        pmem_resp = 1'b0;
        #1;
        chk("rmid_stay_idle", {31'd0, pmem_read}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
